// File: rtl/lsu_pkg.sv
// Shared types and helpers for the load/store bus master.
// Latency: n/a (package only).
// Backpressure: n/a (package only).
package lsu_pkg;

    // Select encodings; these mirror the core's memory-stage macro definitions.
    localparam logic [2:0] LOAD_SEL_LB   = 3'd0;
    localparam logic [2:0] LOAD_SEL_LH   = 3'd1;
    localparam logic [2:0] LOAD_SEL_LW   = 3'd2;
    localparam logic [2:0] LOAD_SEL_LBU  = 3'd4;
    localparam logic [2:0] LOAD_SEL_LHU  = 3'd5;

    localparam logic [1:0] STORE_SEL_SB  = 2'd0;
    localparam logic [1:0] STORE_SEL_SH  = 2'd1;
    localparam logic [1:0] STORE_SEL_SW  = 2'd2;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_REQ0  = 3'd1,
        ST_WAIT0 = 3'd2,
        ST_REQ1  = 3'd3,
        ST_WAIT1 = 3'd4,
        ST_RESP  = 3'd5
    } state_t;

    // Per-transaction control captured at accept time.
    typedef struct packed {
        logic       we;
        logic [2:0] load_sel;
        logic [1:0] off;
        logic [2:0] size;   // 0 marks an invalid select code
        logic       split;
    } meta_t;

    // Access size in bytes; 0 for an unknown select code.
    function automatic logic [2:0] size_of(input logic       we,
                                           input logic [2:0] load_sel,
                                           input logic [1:0] store_sel);
        logic [2:0] sz;
        sz = 3'd0;
        if (we) begin
            case (store_sel)
                STORE_SEL_SB: sz = 3'd1;
                STORE_SEL_SH: sz = 3'd2;
                STORE_SEL_SW: sz = 3'd4;
                default:      sz = 3'd0;
            endcase
        end else begin
            case (load_sel)
                LOAD_SEL_LB, LOAD_SEL_LBU: sz = 3'd1;
                LOAD_SEL_LH, LOAD_SEL_LHU: sz = 3'd2;
                LOAD_SEL_LW:               sz = 3'd4;
                default:                   sz = 3'd0;
            endcase
        end
        return sz;
    endfunction

    // Right-justified byte mask for a given size.
    function automatic logic [3:0] be_mask(input logic [2:0] size);
        logic [3:0] m;
        case (size)
            3'd1:    m = 4'b0001;
            3'd2:    m = 4'b0011;
            3'd4:    m = 4'b1111;
            default: m = 4'b0000;
        endcase
        return m;
    endfunction

    // Mask shifted across a two-word window: [3:0] first word, [7:4] second word.
    function automatic logic [7:0] be_span(input logic [3:0] mask, input logic [1:0] off);
        return {4'b0000, mask} << off;
    endfunction

    // Store data shifted across a two-word window: [31:0] first word, [63:32] second.
    function automatic logic [63:0] lane_shl(input logic [31:0] data, input logic [1:0] off);
        return {32'd0, data} << {off, 3'b000};
    endfunction

    // Load data pulled down from the two-word window so the addressed byte sits at bit 0.
    function automatic logic [31:0] lane_shr(input logic [31:0] word1,
                                             input logic [31:0] word0,
                                             input logic [1:0]  off);
        logic [63:0] t;
        t = {word1, word0} >> {off, 3'b000};
        return t[31:0];
    endfunction

endpackage

// File: rtl/lsu_load_align.sv
// Aligns the captured bus word(s) and extends the load result.
// Latency: combinational.
// Backpressure: none; output follows inputs.
module lsu_load_align
    import lsu_pkg::*;
(
    input  logic [31:0] word0,
    input  logic [31:0] word1,
    input  logic [1:0]  off,
    input  logic [2:0]  load_sel,
    output logic [31:0] rdata
);

    logic [31:0] raw;

    // Shift the addressed bytes to bit 0, then sign- or zero-extend by select.
    always_comb begin
        raw = lane_shr(word1, word0, off);
        case (load_sel)
            LOAD_SEL_LB:  rdata = {{24{raw[7]}},  raw[7:0]};
            LOAD_SEL_LH:  rdata = {{16{raw[15]}}, raw[15:0]};
            LOAD_SEL_LW:  rdata = raw;
            LOAD_SEL_LBU: rdata = {24'd0, raw[7:0]};
            LOAD_SEL_LHU: rdata = {16'd0, raw[15:0]};
            default:      rdata = 32'd0;
        endcase
    end

endmodule

// File: rtl/lsu_bus_master.sv
// Core load/store to word bus initiator; splits word-crossing accesses.
// Latency: accept->rsp 2 (store) / 3 (load), split 3 / 5, plus grant/rvalid stalls.
// Backpressure: req_ready only in IDLE; bus outputs held until bus_gnt.
module lsu_bus_master
    import lsu_pkg::*;
#(
    parameter int ADDR_W = 32
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_we,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [31:0]       req_wdata,
    input  logic [2:0]        load_sel,
    input  logic [1:0]        store_sel,
    output logic              rsp_valid,
    output logic [31:0]       rsp_rdata,
    output logic              busy,
    output logic              bus_req,
    input  logic              bus_gnt,
    output logic [ADDR_W-1:0] bus_addr,
    output logic              bus_we,
    output logic [3:0]        bus_be,
    output logic [31:0]       bus_wdata,
    input  logic              bus_rvalid,
    input  logic [31:0]       bus_rdata
);

    state_t              state_q, state_d;
    logic [ADDR_W-3:0]   waddr_q;
    logic [31:0]         wdata_q;
    logic [31:0]         word0_q, word1_q;
    meta_t               meta_q, meta_acc;
    logic                accept;
    logic [3:0]          span_sum;
    logic [7:0]          be_win;
    logic [63:0]         wdata_win;
    logic [31:0]         align_rdata;

    assign accept = (state_q == ST_IDLE) && req_valid;

    // Decode the incoming request into the control bundle stored at accept.
    always_comb begin
        meta_acc          = '0;
        meta_acc.we       = req_we;
        meta_acc.load_sel = load_sel;
        meta_acc.off      = req_addr[1:0];
        meta_acc.size     = size_of(req_we, load_sel, store_sel);
        span_sum          = {2'b00, req_addr[1:0]} + {1'b0, meta_acc.size};
        meta_acc.split    = (span_sum > 4'd4);
    end

    // State register; reset abandons any transaction in flight.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state: walk the one or two bus accesses, then a single response cycle.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: begin
                if (req_valid) begin
                    state_d = (meta_acc.size == 3'd0) ? ST_RESP : ST_REQ0;
                end
            end
            ST_REQ0: begin
                if (bus_gnt) begin
                    if (meta_q.we) begin
                        state_d = meta_q.split ? ST_REQ1 : ST_RESP;
                    end else begin
                        state_d = ST_WAIT0;
                    end
                end
            end
            ST_WAIT0: begin
                if (bus_rvalid) begin
                    state_d = meta_q.split ? ST_REQ1 : ST_RESP;
                end
            end
            ST_REQ1: begin
                if (bus_gnt) begin
                    state_d = meta_q.we ? ST_RESP : ST_WAIT1;
                end
            end
            ST_WAIT1: begin
                if (bus_rvalid) begin
                    state_d = ST_RESP;
                end
            end
            ST_RESP:  state_d = ST_IDLE;
            default:  state_d = ST_IDLE;
        endcase
    end

    // Request capture at accept; read words captured only in their WAIT state.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            waddr_q <= '0;
            wdata_q <= '0;
            meta_q  <= '0;
            word0_q <= '0;
            word1_q <= '0;
        end else begin
            if (accept) begin
                waddr_q <= req_addr[ADDR_W-1:2];
                wdata_q <= req_wdata;
                meta_q  <= meta_acc;
                word0_q <= '0;
                word1_q <= '0;
            end
            if ((state_q == ST_WAIT0) && bus_rvalid) begin
                word0_q <= bus_rdata;
            end
            if ((state_q == ST_WAIT1) && bus_rvalid) begin
                word1_q <= bus_rdata;
            end
        end
    end

    assign be_win    = be_span(be_mask(meta_q.size), meta_q.off);
    assign wdata_win = lane_shl(wdata_q, meta_q.off);

    // Bus outputs decoded from state and registered request only, so they hold until grant.
    always_comb begin
        bus_req   = 1'b0;
        bus_addr  = '0;
        bus_we    = 1'b0;
        bus_be    = 4'b0000;
        bus_wdata = 32'd0;
        case (state_q)
            ST_REQ0: begin
                bus_req   = 1'b1;
                bus_addr  = {waddr_q, 2'b00};
                bus_we    = meta_q.we;
                bus_be    = be_win[3:0];
                bus_wdata = wdata_win[31:0];
            end
            ST_REQ1: begin
                bus_req   = 1'b1;
                bus_addr  = {waddr_q, 2'b00} + ADDR_W'(4);
                bus_we    = meta_q.we;
                bus_be    = be_win[7:4];
                bus_wdata = wdata_win[63:32];
            end
            default: ;
        endcase
    end

    lsu_load_align u_align (
        .word0    (word0_q),
        .word1    (word1_q),
        .off      (meta_q.off),
        .load_sel (meta_q.load_sel),
        .rdata    (align_rdata)
    );

    assign req_ready = (state_q == ST_IDLE);
    assign busy      = !req_ready;
    assign rsp_valid = (state_q == ST_RESP);
    assign rsp_rdata = (rsp_valid && !meta_q.we) ? align_rdata : 32'd0;

endmodule
